// File: rtl/network_rx_frame_filter.sv
// Store-and-forward RX frame filter: buffers each MAC frame whole, forwards it only
// when it ends with good FCS (tuser=0) and fits, silently dropping everything else.
module network_rx_frame_filter #(
  parameter int DEPTH = 512,
  parameter int CNT_W = 32
) (
  input  logic             clk156,
  input  logic             aresetn,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] stat_frames_ok,
  output logic [CNT_W-1:0] stat_frames_err,
  output logic [CNT_W-1:0] stat_frames_ovf
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = 64 + 8 + 1;

  typedef logic [ADDR_W:0] ptr_t;
  typedef enum logic {ACCEPT, DROP} wr_state_t;

  wr_state_t         state, state_nxt;
  ptr_t              wr_ptr, wr_ptr_nxt, commit_ptr, commit_ptr_nxt, rd_ptr;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rq_word;
  logic              rq_vld, beat, full, avail, rd_en, out_ld;
  logic              mem_we, inc_ok, inc_err, inc_ovf;

  // Extra pointer bit distinguishes full from empty.
  assign beat  = s_axis_tvalid & s_axis_tready;
  assign full  = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
  assign avail = (rd_ptr != commit_ptr);

  // Two-stage read: RAM output stage feeds the AXI output register; RAM stage
  // refills in the same cycle it drains so the output runs at full rate.
  assign out_ld = rq_vld & (~m_axis_tvalid | m_axis_tready);
  assign rd_en  = avail & (~rq_vld | out_ld);

  // Write FSM: per accepted beat decide store / commit / rewind / drop.
  always_comb begin
    state_nxt      = state;
    wr_ptr_nxt     = wr_ptr;
    commit_ptr_nxt = commit_ptr;
    mem_we         = 1'b0;
    inc_ok         = 1'b0;
    inc_err        = 1'b0;
    inc_ovf        = 1'b0;
    if (beat) begin
      case (state)
        ACCEPT: begin
          if (full) begin
            wr_ptr_nxt = commit_ptr;
            if (s_axis_tlast) inc_ovf = 1'b1;
            else              state_nxt = DROP;
          end else begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + ptr_t'(1);
            if (s_axis_tlast) begin
              if (!s_axis_tuser) begin
                commit_ptr_nxt = wr_ptr + ptr_t'(1);
                inc_ok         = 1'b1;
              end else begin
                wr_ptr_nxt = commit_ptr;
                inc_err    = 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (s_axis_tlast) begin
            inc_ovf   = 1'b1;
            state_nxt = ACCEPT;
          end
        end
        default: state_nxt = ACCEPT;
      endcase
    end
  end

  // Write-side state, pointers and statistics.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      state           <= ACCEPT;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      stat_frames_ok  <= '0;
      stat_frames_err <= '0;
      stat_frames_ovf <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      commit_ptr <= commit_ptr_nxt;
      if (inc_ok)  stat_frames_ok  <= stat_frames_ok  + CNT_W'(1);
      if (inc_err) stat_frames_err <= stat_frames_err + CNT_W'(1);
      if (inc_ovf) stat_frames_ovf <= stat_frames_ovf + CNT_W'(1);
    end
  end

  // MAC cannot stall: ready rises on the first edge after reset and stays up.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) s_axis_tready <= 1'b0;
    else          s_axis_tready <= 1'b1;
  end

  // Frame buffer; read only touches committed words, so it never collides with writes.
  always_ff @(posedge clk156) begin
    if (mem_we) mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
    if (rd_en)  rq_word <= mem[rd_ptr[ADDR_W-1:0]];
  end

  // Read pointer and RAM-stage valid.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr <= '0;
      rq_vld <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
      if (rd_en)       rq_vld <= 1'b1;
      else if (out_ld) rq_vld <= 1'b0;
    end
  end

  // AXI output register; holds while tvalid & !tready.
  always_ff @(posedge clk156 or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (out_ld) begin
      {m_axis_tdata, m_axis_tkeep, m_axis_tlast} <= rq_word;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_network_rx_frame_filter.sv
// Bench for network_rx_frame_filter: two instances (DEPTH 512 and 16) share stimulus;
// each scenario checks whichever instance its expectations apply to.
module tb_network_rx_frame_filter;
  localparam int NI = 2;

  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic                  aresetn;
  logic [63:0]           s_tdata;
  logic [7:0]            s_tkeep;
  logic                  s_tvalid, s_tlast, s_tuser, m_tready;
  logic [NI-1:0]         s_tready, m_tvalid, m_tlast;
  logic [NI-1:0][63:0]   m_tdata;
  logic [NI-1:0][7:0]    m_tkeep;
  logic [NI-1:0][31:0]   st_ok, st_err, st_ovf;

  network_rx_frame_filter #(.DEPTH(512), .CNT_W(32)) u_big (
    .clk156(clk156), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tkeep(m_tkeep[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready),
    .stat_frames_ok(st_ok[0]), .stat_frames_err(st_err[0]), .stat_frames_ovf(st_ovf[0]));

  network_rx_frame_filter #(.DEPTH(16), .CNT_W(32)) u_small (
    .clk156(clk156), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tkeep(m_tkeep[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready),
    .stat_frames_ok(st_ok[1]), .stat_frames_err(st_err[1]), .stat_frames_ovf(st_ovf[1]));

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  bit rnd_mode = 1'b0;
  bit tready_force = 1'b0;

  logic [72:0] oq0[$], oq1[$], expq[$];
  int unsigned ot0[$];

  typedef struct {
    int len;
    bit bad;
    int exp_ok;
    int exp_err;
  } fvec_t;
  fvec_t vecs[7];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk156); #1; end
  endtask

  // Downstream ready: fixed level or 50% random, applied after the main driver.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk156); #2;
      m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : tready_force;
    end
  end

  // Output monitor: collects handshaken beats and checks hold-while-stalled.
  logic [NI-1:0]       stall_q;
  logic [NI-1:0][72:0] stall_w;
  initial begin
    stall_q = '0;
    stall_w = '0;
    forever begin
      @(negedge clk156);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (!aresetn) stall_q[i] = 1'b0;
        else begin
          if (stall_q[i]) begin
            checks++;
            if (!m_tvalid[i] || {m_tdata[i], m_tkeep[i], m_tlast[i]} != stall_w[i]) begin
              failures++;
              $display("FAIL hold_stable dut%0d: got v=%0b w=%h expected v=1 w=%h",
                       i, m_tvalid[i], {m_tdata[i], m_tkeep[i], m_tlast[i]}, stall_w[i]);
            end
          end
          if (m_tvalid[i] && m_tready) begin
            if (i == 0) begin
              oq0.push_back({m_tdata[i], m_tkeep[i], m_tlast[i]});
              ot0.push_back(cyc);
            end else oq1.push_back({m_tdata[i], m_tkeep[i], m_tlast[i]});
          end
          stall_q[i] = m_tvalid[i] && !m_tready;
          stall_w[i] = {m_tdata[i], m_tkeep[i], m_tlast[i]};
        end
      end
    end
  end

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    s_tdata  = '0;   s_tkeep = '0;
    oq0.delete(); oq1.delete(); ot0.delete(); expq.delete();
    tick(3);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_tvalid%0d", i), m_tvalid[i], 0);
      chk($sformatf("rst_tready%0d", i), s_tready[i], 0);
      chk($sformatf("rst_ok%0d", i), st_ok[i], 0);
    end
    aresetn = 1'b1;
    #1;
    chk("rst_tready_post_release", s_tready, 0);
    tick(1);
    chk("rst_tready_first_edge", s_tready, 2'b11);
  endtask

  // Sends one frame; the caller states whether the frame should come out.
  task automatic send_frame(input int len, input bit bad, input int fid, input bit bubbles,
                            input bit fwd);
    for (int b = 0; b < len; b++) begin
      if (bubbles) while ($urandom_range(0, 3) == 0) begin s_tvalid = 1'b0; tick(1); end
      s_tdata  = {fid[15:0], b[15:0], $urandom()};
      s_tkeep  = 8'($urandom_range(1, 255));
      s_tlast  = (b == len - 1);
      s_tuser  = (b == len - 1) ? bad : 1'($urandom_range(0, 1));
      s_tvalid = 1'b1;
      if (fwd) expq.push_back({s_tdata, s_tkeep, s_tlast});
      tick(1);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic drain(input int inst, input int maxcyc);
    int k;
    k = 0;
    while (((inst == 0) ? oq0.size() : oq1.size()) < expq.size() && k < maxcyc) begin
      tick(1);
      k++;
    end
    tick(4);
  endtask

  task automatic cmp_out(input int inst, input string nm);
    int n;
    n = (inst == 0) ? oq0.size() : oq1.size();
    chk({nm, "_count"}, n, expq.size());
    for (int k = 0; k < expq.size() && k < n; k++)
      chk($sformatf("%s_beat%0d", nm, k), (inst == 0) ? oq0[k] : oq1[k], expq[k]);
  endtask

  int outstanding;
  int n_ok, n_err, wt, len;
  bit bad;

  initial begin
    vecs[0] = '{8,  1'b0, 1, 0};
    vecs[1] = '{1,  1'b0, 2, 0};
    vecs[2] = '{60, 1'b0, 3, 0};
    vecs[3] = '{10, 1'b1, 3, 1};
    vecs[4] = '{5,  1'b0, 4, 1};
    vecs[5] = '{1,  1'b1, 4, 2};
    vecs[6] = '{2,  1'b0, 5, 2};

    aresetn = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; s_tdata = '0; s_tkeep = '0;
    #1;

    // Latency: single-beat frame, first output no earlier than T+2.
    tready_force = 1'b1;
    do_reset();
    send_frame(1, 1'b0, 1, 1'b0, 1'b1);
    chk("lat_T0", m_tvalid[0], 0);
    tick(1);
    chk("lat_T1", m_tvalid[0], 0);
    chk("lat_ok_cnt", st_ok[0], 1);
    tick(1);
    chk("lat_T2", m_tvalid[0], 1);
    chk("lat_word", {m_tdata[0], m_tkeep[0], m_tlast[0]}, expq[0]);
    drain(0, 50);
    cmp_out(0, "lat");

    // Good/bad frame table on the large buffer, tready=1.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].len, vecs[i].bad, 100 + i, 1'b0, !vecs[i].bad);
      tick(1);
      chk($sformatf("tbl%0d_ok", i), st_ok[0], vecs[i].exp_ok);
      chk($sformatf("tbl%0d_err", i), st_err[0], vecs[i].exp_err);
      chk($sformatf("tbl%0d_ovf", i), st_ovf[0], 0);
    end
    drain(0, 500);
    cmp_out(0, "tbl");
    if (ot0.size() >= 69) begin
      chk("tbl_rate_f0", ot0[7] - ot0[0], 7);
      chk("tbl_rate_f2", ot0[68] - ot0[9], 59);
    end

    // Oversized frame on DEPTH=16, then a good frame comes through intact.
    tready_force = 1'b0;
    do_reset();
    send_frame(20, 1'b0, 300, 1'b0, 1'b0);
    tick(2);
    chk("ovf20_ovf", st_ovf[1], 1);
    chk("ovf20_ok", st_ok[1], 0);
    chk("ovf20_err", st_err[1], 0);
    chk("ovf20_tvalid", m_tvalid[1], 0);
    send_frame(4, 1'b0, 301, 1'b0, 1'b1);
    tick(1);
    chk("ovf20_next_ok", st_ok[1], 1);
    tready_force = 1'b1;
    drain(1, 200);
    cmp_out(1, "ovf20");

    // Buffer filled by two frames while stalled; third frame overflows.
    tready_force = 1'b0;
    do_reset();
    send_frame(8, 1'b0, 400, 1'b0, 1'b1);
    send_frame(8, 1'b0, 401, 1'b0, 1'b1);
    send_frame(8, 1'b0, 402, 1'b0, 1'b0);
    tick(2);
    chk("fill_ovf", st_ovf[1], 1);
    chk("fill_ok", st_ok[1], 2);
    tready_force = 1'b1;
    drain(1, 200);
    cmp_out(1, "fill");

    // Random frames, random ready, bubbles; sender keeps in-flight data within 16 words.
    tready_force = 1'b1;
    do_reset();
    rnd_mode = 1'b1;
    n_ok = 0; n_err = 0;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 16);
      bad = ($urandom_range(0, 4) == 0);
      wt  = 0;
      outstanding = expq.size() - ((oq0.size() < oq1.size()) ? oq0.size() : oq1.size());
      while (outstanding + len > 16 && wt < 2000) begin
        tick(1);
        wt++;
        outstanding = expq.size() - ((oq0.size() < oq1.size()) ? oq0.size() : oq1.size());
      end
      if (wt >= 2000) begin
        failures++;
        $display("FAIL rnd_throttle_timeout: outstanding %0d expected <= %0d", outstanding, 16 - len);
      end
      send_frame(len, bad, 1000 + f, 1'b1, !bad);
      if (bad) n_err++; else n_ok++;
      tick($urandom_range(0, 3));
    end
    rnd_mode = 1'b0;
    drain(0, 2000);
    drain(1, 2000);
    cmp_out(0, "rnd0");
    cmp_out(1, "rnd1");
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rnd_ok%0d", i), st_ok[i], n_ok);
      chk($sformatf("rnd_err%0d", i), st_err[i], n_err);
      chk($sformatf("rnd_ovf%0d", i), st_ovf[i], 0);
    end

    // Reset mid-frame with committed data buffered and output stalled.
    tready_force = 1'b0;
    do_reset();
    send_frame(4, 1'b0, 600, 1'b0, 1'b0);
    send_frame(4, 1'b0, 601, 1'b0, 1'b0);
    for (int b = 0; b < 3; b++) begin
      s_tdata = {32'h0000_0602, $urandom()}; s_tkeep = 8'hff;
      s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
      tick(1);
    end
    chk("mid_pre_ok", st_ok[0], 2);
    chk("mid_pre_tvalid", m_tvalid[1], 1);
    aresetn = 1'b0;
    s_tvalid = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("mid_tvalid%0d", i), m_tvalid[i], 0);
      chk($sformatf("mid_tdata%0d", i), {m_tdata[i], m_tkeep[i], m_tlast[i]}, 0);
      chk($sformatf("mid_tready%0d", i), s_tready[i], 0);
      chk($sformatf("mid_stats%0d", i), {st_ok[i], st_err[i], st_ovf[i]}, 0);
    end
    tick(3);
    aresetn = 1'b1;
    tready_force = 1'b1;
    tick(30);
    chk("mid_post_beats0", oq0.size(), 0);
    chk("mid_post_beats1", oq1.size(), 0);
    chk("mid_post_tvalid", m_tvalid, 0);
    send_frame(2, 1'b0, 603, 1'b0, 1'b1);
    drain(0, 50);
    drain(1, 50);
    cmp_out(0, "mid_new0");
    cmp_out(1, "mid_new1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
